// File: rtl/msdap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msdap_pkg
//  Description : Shared constants and types for the MSDAP serial front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package msdap_pkg;

    localparam int WORD_BITS   = 16;
    localparam int RJ_WORDS    = 16;
    localparam int COEFF_WORDS = 512;
    localparam int INDEX_W     = 10;
    localparam int BITCNT_W    = $clog2(WORD_BITS) + 1;

    // Tag of a received word, from its position in the load sequence
    typedef enum logic [1:0] {
        PH_RJ    = 2'd0,
        PH_COEFF = 2'd1,
        PH_DATA  = 2'd2
    } phase_e;

    // Word deserialiser states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/msdap_frame_rx_if.sv
`default_nettype none
// ============================================================================
//  Module      : msdap_frame_rx_if
//  Description : Serial input pins and received-word bus of the MSDAP front end.
//  Revision    : 1.0 - initial release
// ============================================================================
interface msdap_frame_rx_if;

    logic                           DCLK;
    logic                           Frame;
    logic                           InputL;
    logic                           InputR;
    logic                           Enable;
    logic                           Restart;
    logic                           rx_valid;
    logic [msdap_pkg::WORD_BITS-1:0] rx_left;
    logic [msdap_pkg::WORD_BITS-1:0] rx_right;
    logic [1:0]                     rx_phase;
    logic [msdap_pkg::INDEX_W-1:0]  rx_index;
    logic                           frame_err;

    // Receiver side
    modport slave (
        input  DCLK, Frame, InputL, InputR, Enable, Restart,
        output rx_valid, rx_left, rx_right, rx_phase, rx_index, frame_err
    );

    // Transmitter / controller side
    modport master (
        output DCLK, Frame, InputL, InputR, Enable, Restart,
        input  rx_valid, rx_left, rx_right, rx_phase, rx_index, frame_err
    );

endinterface
`default_nettype wire

// File: rtl/msdap_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : msdap_sync_edge
//  Description : Two-flop synchroniser for one bit, optional falling-edge pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module msdap_sync_edge #(
    parameter bit FALL_EN = 1'b0
) (
    input  logic Sclk,
    input  logic Reset,
    input  logic d_i,
    output logic q_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage metastability filter
    always_ff @(posedge Sclk or posedge Reset) begin
        if (Reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

    generate
        if (FALL_EN) begin : g_fall
            logic prev_q;

            // Delayed copy of the synchronised level for edge detection
            always_ff @(posedge Sclk or posedge Reset) begin
                if (Reset) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= sync_q;
                end
            end

            assign fall_o = prev_q & ~sync_q;
        end else begin : g_no_fall
            assign fall_o = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/msdap_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : msdap_frame_rx
//  Description : Oversampling deserialiser for framed 16-bit L/R serial words,
//                tagging each word as Rj, coefficient or data.
//  Revision    : 1.0 - initial release
// ============================================================================
module msdap_frame_rx
    import msdap_pkg::*;
(
    input  logic            Sclk,
    input  logic            Reset,
    msdap_frame_rx_if.slave bus
);

    logic       dclk_fall;
    logic       frame_s;
    logic       inl_s;
    logic       inr_s;
    logic       unused_dclk_lvl;
    logic [2:0] unused_fall;

    msdap_sync_edge #(.FALL_EN(1'b1)) u_sync_dclk (
        .Sclk(Sclk), .Reset(Reset), .d_i(bus.DCLK),
        .q_o(unused_dclk_lvl), .fall_o(dclk_fall)
    );
    msdap_sync_edge #(.FALL_EN(1'b0)) u_sync_frame (
        .Sclk(Sclk), .Reset(Reset), .d_i(bus.Frame),
        .q_o(frame_s), .fall_o(unused_fall[0])
    );
    msdap_sync_edge #(.FALL_EN(1'b0)) u_sync_inl (
        .Sclk(Sclk), .Reset(Reset), .d_i(bus.InputL),
        .q_o(inl_s), .fall_o(unused_fall[1])
    );
    msdap_sync_edge #(.FALL_EN(1'b0)) u_sync_inr (
        .Sclk(Sclk), .Reset(Reset), .d_i(bus.InputR),
        .q_o(inr_s), .fall_o(unused_fall[2])
    );

    rx_state_e              state_q, state_d;
    logic [BITCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [WORD_BITS-1:0]   shl_q, shl_d;
    logic [WORD_BITS-1:0]   shr_q, shr_d;
    logic                   valid_q, valid_d;
    logic                   ferr_q, ferr_d;
    logic [WORD_BITS-1:0]   left_q, left_d;
    logic [WORD_BITS-1:0]   right_q, right_d;
    phase_e                 out_phase_q, out_phase_d;
    logic [INDEX_W-1:0]     out_index_q, out_index_d;
    phase_e                 phase_q, phase_d;      // tag for the next word
    logic [INDEX_W-1:0]     index_q, index_d;
    logic                   w_complete;

    // Last bit of a word arrives on this sample (Frame low, 15 bits held)
    assign w_complete = dclk_fall && (state_q == ST_SHIFT) && !frame_s &&
                        (bit_cnt_q == BITCNT_W'(WORD_BITS - 1));

    // Next-state: deserialiser FSM, output capture and phase/index counter
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shl_d       = shl_q;
        shr_d       = shr_q;
        valid_d     = 1'b0;
        ferr_d      = 1'b0;
        left_d      = left_q;
        right_d     = right_q;
        out_phase_d = out_phase_q;
        out_index_d = out_index_q;
        phase_d     = phase_q;
        index_d     = index_q;

        if (bus.Restart) begin
            // Restart beats a coinciding word completion
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            phase_d   = PH_RJ;
            index_d   = '0;
        end else if (w_complete) begin
            // Delivered even if Enable drops on this very cycle
            valid_d     = 1'b1;
            left_d      = {shl_q[WORD_BITS-2:0], inl_s};
            right_d     = {shr_q[WORD_BITS-2:0], inr_s};
            out_phase_d = phase_q;
            out_index_d = index_q;
            state_d     = ST_IDLE;
            bit_cnt_d   = '0;
            unique case (phase_q)
                PH_RJ: begin
                    if (index_q == INDEX_W'(RJ_WORDS - 1)) begin
                        phase_d = PH_COEFF;
                        index_d = '0;
                    end else begin
                        index_d = index_q + INDEX_W'(1);
                    end
                end
                PH_COEFF: begin
                    if (index_q == INDEX_W'(COEFF_WORDS - 1)) begin
                        phase_d = PH_DATA;
                        index_d = '0;
                    end else begin
                        index_d = index_q + INDEX_W'(1);
                    end
                end
                default: index_d = index_q + INDEX_W'(1);  // DATA wraps mod 1024
            endcase
        end else if (!bus.Enable) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
        end else if (dclk_fall) begin
            if (frame_s) begin
                // Frame always starts a new word; mid-word it is an error
                ferr_d    = (state_q == ST_SHIFT);
                shl_d     = {{(WORD_BITS-1){1'b0}}, inl_s};
                shr_d     = {{(WORD_BITS-1){1'b0}}, inr_s};
                bit_cnt_d = BITCNT_W'(1);
                state_d   = ST_SHIFT;
            end else if (state_q == ST_SHIFT) begin
                shl_d     = {shl_q[WORD_BITS-2:0], inl_s};
                shr_d     = {shr_q[WORD_BITS-2:0], inr_s};
                bit_cnt_d = bit_cnt_q + BITCNT_W'(1);
            end
        end
    end

    // State and output registers
    always_ff @(posedge Sclk or posedge Reset) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shl_q       <= '0;
            shr_q       <= '0;
            valid_q     <= 1'b0;
            ferr_q      <= 1'b0;
            left_q      <= '0;
            right_q     <= '0;
            out_phase_q <= PH_RJ;
            out_index_q <= '0;
            phase_q     <= PH_RJ;
            index_q     <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shl_q       <= shl_d;
            shr_q       <= shr_d;
            valid_q     <= valid_d;
            ferr_q      <= ferr_d;
            left_q      <= left_d;
            right_q     <= right_d;
            out_phase_q <= out_phase_d;
            out_index_q <= out_index_d;
            phase_q     <= phase_d;
            index_q     <= index_d;
        end
    end

    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_left   = left_q;
    assign bus.rx_right  = right_q;
    assign bus.rx_phase  = out_phase_q;
    assign bus.rx_index  = out_index_q;

endmodule
`default_nettype wire

// File: tb/tb_msdap_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msdap_frame_rx
//  Description : Self-checking bench for msdap_frame_rx with a word-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msdap_frame_rx;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
        logic [1:0]  ph;
        logic [9:0]  idx;
    } rec_t;

    logic Sclk = 1'b0;
    logic Reset;

    always #5 Sclk = ~Sclk;

    msdap_frame_rx_if bus_if();

    msdap_frame_rx dut (
        .Sclk (Sclk),
        .Reset(Reset),
        .bus  (bus_if)
    );

    int   n_checks = 0;
    int   n_errors = 0;
    int   word_n   = 0;   // words accepted since the last Restart/Reset
    int   err_seen = 0;
    int   err_exp  = 0;
    rec_t obs_q[$];
    rec_t exp_q[$];

    // Capture every output pulse
    always @(negedge Sclk) begin
        if (bus_if.rx_valid)
            obs_q.push_back({bus_if.rx_left, bus_if.rx_right, bus_if.rx_phase, bus_if.rx_index});
        if (bus_if.frame_err)
            err_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference tag: position in the load sequence, Rj(16) then coeff(512) then data
    function automatic void expect_word(input logic [15:0] l, input logic [15:0] r);
        rec_t e;
        e.l = l;
        e.r = r;
        if (word_n < 16) begin
            e.ph  = 2'd0;
            e.idx = 10'(word_n);
        end else if (word_n < 16 + 512) begin
            e.ph  = 2'd1;
            e.idx = 10'(word_n - 16);
        end else begin
            e.ph  = 2'd2;
            e.idx = 10'((word_n - 528) % 1024);
        end
        exp_q.push_back(e);
        word_n++;
    endfunction

    // Transmit nbits MSB-first; data and Frame change right after DCLK rises
    task automatic send_bits(input logic [15:0] l, input logic [15:0] r,
                             input int nbits, input int half, input bit framed);
        for (int i = 0; i < nbits; i++) begin
            bus_if.DCLK   = 1'b1;
            bus_if.Frame  = framed && (i == 0);
            bus_if.InputL = l[15-i];
            bus_if.InputR = r[15-i];
            repeat (half) @(posedge Sclk);
            #1;
            bus_if.DCLK = 1'b0;
            repeat (half) @(posedge Sclk);
            #1;
        end
    endtask

    task automatic send_word(input logic [15:0] l, input logic [15:0] r, input int half);
        send_bits(l, r, 16, half, 1'b1);
        expect_word(l, r);
    endtask

    task automatic pulse_restart();
        bus_if.Restart = 1'b1;
        @(posedge Sclk);
        #1;
        bus_if.Restart = 1'b0;
        word_n = 0;
    endtask

    // Compare everything observed against the model and empty both queues
    task automatic drain(input string tag);
        rec_t o;
        rec_t e;
        repeat (12) @(posedge Sclk);
        #1;
        check({tag, "_count"}, 32'(obs_q.size()), 32'(exp_q.size()));
        check({tag, "_ferr"}, 32'(err_seen), 32'(err_exp));
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_left"},  32'(o.l),   32'(e.l));
            check({tag, "_right"}, 32'(o.r),   32'(e.r));
            check({tag, "_phase"}, 32'(o.ph),  32'(e.ph));
            check({tag, "_index"}, 32'(o.idx), 32'(e.idx));
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 32'(bus_if.rx_valid),  32'd0);
        check({tag, "_ferr"},  32'(bus_if.frame_err), 32'd0);
        check({tag, "_left"},  32'(bus_if.rx_left),   32'd0);
        check({tag, "_right"}, 32'(bus_if.rx_right),  32'd0);
        check({tag, "_phase"}, 32'(bus_if.rx_phase),  32'd0);
        check({tag, "_index"}, 32'(bus_if.rx_index),  32'd0);
    endtask

    initial begin
        Reset          = 1'b1;
        bus_if.DCLK    = 1'b0;
        bus_if.Frame   = 1'b0;
        bus_if.InputL  = 1'b0;
        bus_if.InputR  = 1'b0;
        bus_if.Enable  = 1'b1;
        bus_if.Restart = 1'b0;
        repeat (3) @(posedge Sclk);
        #1;
        check_reset_outputs("rst");
        Reset = 1'b0;
        repeat (3) @(posedge Sclk);
        #1;

        // Single known frame
        send_word(16'h8001, 16'h7FFE, 18);
        drain("single");

        // Bits with Frame low are ignored, then a normal frame
        send_bits(16'($urandom), 16'($urandom), 16, 18, 1'b0);
        send_bits(16'($urandom), 16'($urandom), 4, 18, 1'b0);
        drain("idle");
        send_word(16'($urandom), 16'($urandom), 18);
        drain("after_idle");

        // Random data at varying legal DCLK rates
        for (int k = 0; k < 2; k++)
            send_word(16'($urandom), 16'($urandom), int'($urandom_range(17, 20)));
        drain("rand");

        // Frame reasserted after 7 bits
        send_bits(16'($urandom), 16'($urandom), 7, 18, 1'b1);
        err_exp++;
        send_word(16'h1234, 16'hABCD, 18);
        drain("frame_err");

        // Enable dropped mid-word
        send_bits(16'($urandom), 16'($urandom), 10, 18, 1'b1);
        bus_if.Enable = 1'b0;
        repeat (40) @(posedge Sclk);
        #1;
        bus_if.Enable = 1'b1;
        send_word(16'($urandom), 16'($urandom), 18);
        drain("enable");

        // Full load sequence from a fresh Rj phase, fast DCLK
        pulse_restart();
        for (int k = 0; k < 16 + 512 + 3; k++)
            send_word(16'($urandom), 16'($urandom), 4);
        drain("load");

        // Restart mid-word while in DATA
        send_bits(16'($urandom), 16'($urandom), 5, 18, 1'b1);
        pulse_restart();
        send_word(16'($urandom), 16'($urandom), 18);
        drain("restart");

        // Asynchronous reset mid-word
        send_bits(16'($urandom), 16'($urandom), 8, 18, 1'b1);
        Reset = 1'b1;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(posedge Sclk);
        #1;
        Reset  = 1'b0;
        word_n = 0;
        repeat (2) @(posedge Sclk);
        #1;
        send_word(16'($urandom), 16'($urandom), 18);
        drain("after_rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
